// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the camera-to-recognizer capture controller.
package frame_capture_pkg;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    WAIT_VS,
    CAPTURE,
    DRAIN,
    WAIT_RES,
    DONE
  } state_e;

endpackage

// File: rtl/frame_capture_ctrl_pix_packer.sv
// Packs accepted pixels four per word, issues registered FIFO writes and parks
// one word in a holding register under backpressure; sticky overflow on loss.
module pix_packer
  import frame_capture_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_accept,
  input  logic [PIX_W-1:0]  i_pix,
  input  logic              i_full,
  output logic              o_wr_en,
  output logic [WORD_W-1:0] o_data,
  output logic              o_hold_valid,
  output logic              o_overflow
);

  localparam int unsigned LANE_W  = WORD_W / PIX_PER_WORD;
  localparam int unsigned LANE_CW = $clog2(PIX_PER_WORD);

  logic [LANE_CW-1:0] r_lane;
  logic [WORD_W-1:0]  r_asm;
  logic [WORD_W-1:0]  r_hold;
  logic [WORD_W-1:0]  r_data;
  logic               r_hold_valid;
  logic               r_wr_en;
  logic               r_ovf;

  logic [LANE_W-1:0]  w_pix_lane;
  logic [WORD_W-1:0]  w_word;
  logic               w_complete;
  logic               w_drain;

  assign w_pix_lane = LANE_W'(i_pix);
  assign w_complete = i_accept && (r_lane == LANE_CW'(PIX_PER_WORD - 1));
  assign w_word     = {w_pix_lane, r_asm[WORD_W-LANE_W-1:0]};
  assign w_drain    = r_hold_valid && !i_full;

  // A parked word drains before a newly completed one; a word completing while
  // the holding register is still occupied is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane       <= '0;
      r_asm        <= '0;
      r_hold       <= '0;
      r_data       <= '0;
      r_hold_valid <= 1'b0;
      r_wr_en      <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (i_clr) begin
        r_lane       <= '0;
        r_asm        <= '0;
        r_hold_valid <= 1'b0;
        r_ovf        <= 1'b0;
      end else begin
        if (i_accept) begin
          r_lane                        <= r_lane + LANE_CW'(1);
          r_asm[r_lane*LANE_W +: LANE_W] <= w_pix_lane;
        end
        if (w_drain) begin
          r_wr_en      <= 1'b1;
          r_data       <= r_hold;
          r_hold_valid <= 1'b0;
        end
        if (w_complete) begin
          if (r_hold_valid) begin
            r_ovf <= 1'b1;
          end else if (i_full) begin
            r_hold       <= w_word;
            r_hold_valid <= 1'b1;
          end else begin
            r_wr_en <= 1'b1;
            r_data  <= w_word;
          end
        end
      end
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_data       = r_data;
  assign o_hold_valid = r_hold_valid;
  assign o_overflow   = r_ovf;

endmodule

// File: rtl/frame_capture_ctrl.sv
// One recognition pass: skip frames, capture an ROI into the recognizer FIFO,
// latch the result. FCC_RESULT_TIMEOUT_EN adds a WAIT_RES timeout and port.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = 3,
  parameter int unsigned ROI_PIXELS  = 784,
  parameter int unsigned PIX_W       = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              cam_full,
  output logic              cam_wr_en,
  output logic [WORD_W-1:0] cam_data,
  input  logic              res_valid,
  input  logic [19:0]       res_in,
  output logic [3:0]        result,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef FCC_RESULT_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam int unsigned FRAME_W   = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int unsigned PIX_CNT_W = $clog2(ROI_PIXELS + 1);

  state_e               r_state;
  state_e               w_state_nx;
  logic                 r_vsync_d;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic [3:0]           r_result;
  logic                 r_busy;
  logic                 r_done;

  logic w_rise;
  logic w_accept;
  logic w_last_pix;
  logic w_frame_hit;
  logic w_start_ok;
  logic w_frame_inc;
  logic w_res_take;
  logic w_tmo;
  logic w_hold_valid;
  logic w_unused_res;

  assign w_rise       = vsync && !r_vsync_d;
  assign w_accept     = (r_state == CAPTURE) && pix_valid && href && !vsync;
  assign w_last_pix   = w_accept && (r_pix_cnt == PIX_CNT_W'(ROI_PIXELS - 1));
  assign w_frame_hit  = (r_frame_cnt == FRAME_W'(SKIP_FRAMES - 1));
  assign w_unused_res = ^res_in[19:4];

`ifdef FCC_RESULT_TIMEOUT_EN
  logic [23:0] r_tmo_cnt;
  logic        r_timeout;
  assign w_tmo = (r_state == WAIT_RES) && !res_valid && (r_tmo_cnt == 24'hFF_FFFF);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_start_ok  = 1'b0;
    w_frame_inc = 1'b0;
    w_res_take  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_start_ok = 1'b1;
          w_state_nx = SKIP;
        end
      end
      SKIP: begin
        if (SKIP_FRAMES == 0) begin
          w_state_nx = WAIT_VS;
        end else if (w_rise) begin
          w_frame_inc = 1'b1;
          if (w_frame_hit) w_state_nx = CAPTURE;
        end
      end
      WAIT_VS:  if (w_rise) w_state_nx = CAPTURE;
      CAPTURE:  if (w_last_pix) w_state_nx = DRAIN;
      DRAIN:    if (!w_hold_valid) w_state_nx = WAIT_RES;
      WAIT_RES: begin
        if (res_valid) begin
          w_res_take = 1'b1;
          w_state_nx = DONE;
        end else if (w_tmo) begin
          w_state_nx = DONE;
        end
      end
      default:  w_state_nx = IDLE;
    endcase
  end

  // Pass counters, result latch and status flags aligned with the state register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vsync_d   <= 1'b0;
      r_frame_cnt <= '0;
      r_pix_cnt   <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (w_start_ok) begin
        r_frame_cnt <= '0;
        r_pix_cnt   <= '0;
      end else begin
        if (w_frame_inc) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        if (w_accept)    r_pix_cnt   <= r_pix_cnt + PIX_CNT_W'(1);
      end
      if (w_res_take)  r_result <= res_in[3:0];
      else if (w_tmo)  r_result <= 4'hF;
      r_busy <= (w_state_nx != IDLE) && (w_state_nx != DONE);
      r_done <= (w_state_nx == DONE);
    end
  end

`ifdef FCC_RESULT_TIMEOUT_EN
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == WAIT_RES) ? r_tmo_cnt + 24'd1 : 24'd0;
      if (w_start_ok) r_timeout <= 1'b0;
      else if (w_tmo) r_timeout <= 1'b1;
    end
  end
  assign timeout = r_timeout;
`endif

  pix_packer #(
    .PIX_W(PIX_W)
  ) u_pix_packer (
    .i_clk       (pclk),
    .i_rst       (rst),
    .i_clr       (w_start_ok),
    .i_accept    (w_accept),
    .i_pix       (pix_in),
    .i_full      (cam_full),
    .o_wr_en     (cam_wr_en),
    .o_data      (cam_data),
    .o_hold_valid(w_hold_valid),
    .o_overflow  (overflow)
  );

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
